input_debounce_capture: RTL
===========================

// Module: input_debounce_capture
// PURPOSE
//  Input-side counterpart of the LED/seven-segment output path on the board top level.
//  - Synchronises and debounces NUM_IN raw push-buttons/switches.
//  - Produces clean levels and single-cycle press pulses.
//  - Holds sticky pending/overrun event flags that the RISC-V CPU reads and clears.
//  - Sits between the board pins and the CPU's input register space.
// PARAMETERS
//  NUM_IN     4      number of independent raw inputs
//  CNT_W      16     debounce counter width
//  DB_CYCLES  50000  consecutive synchronised cycles required to accept a new level; 2 <= DB_CYCLES < 2**CNT_W
// PORTS
//  clk          in   1       system clock
//  rst          in   1       asynchronous, active-low reset
//  raw_in       in   NUM_IN  asynchronous board inputs (buttons/switches)
//  clr_en       in   1       CPU clear strobe, 1 cycle
//  clr_mask     in   NUM_IN  bits to clear in pending/overrun when clr_en=1
//  stable_out   out  NUM_IN  debounced level, registered
//  press_pulse  out  NUM_IN  1-cycle pulse on each accepted 0->1 transition
//  pending      out  NUM_IN  sticky press flag
//  overrun      out  NUM_IN  sticky: a press arrived while pending was already 1
//  irq          out  1       OR-reduction of pending, registered
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - All outputs 0; sync flops 0; counters 0; every FSM in S0.
//  Synchroniser: per-bit 2-flop synchroniser on raw_in; sync = second flop.
//  Per-bit FSM (4 states):
//   - S0: level 0, idle.
//   - W1: waiting to accept 1.
//   - S1: level 1, idle.
//   - W0: waiting to accept 0.
//  Transitions:
//   - S0 -> W1 when sync=1; counter loads 1.
//   - W1 -> S0 when sync=0; counter cleared (glitch rejected).
//   - In W1, counter increments while sync=1.
//   - W1 -> S1 when sync=1 and counter == DB_CYCLES-1.
//   - S1/W0 mirror S0/W1 with levels inverted.
//  On entry to S1:
//   - stable_out=1 and press_pulse=1 for exactly 1 cycle.
//  On entry to S0:
//   - stable_out=0; no pulse (see RELEASE_EVT_EN).
//  Latency:
//   - A raw edge sampled at clock edge 0 and held reaches stable_out at edge 2+DB_CYCLES.
//   - pending and irq follow 1 cycle after press_pulse.
//  Pending/overrun update each cycle, per bit:
//   - set = press_pulse; clr = clr_en & clr_mask.
//   - pending <= set | (pending & ~clr): set wins over a simultaneous clear, so no event is lost.
//   - overrun <= (set & pending) | (overrun & ~clr).
//  Counter:
//   - Saturates at DB_CYCLES-1.
//   - Never wraps; cleared on every state change.
//  Bits are fully independent; simultaneous events on several bits are all captured.
//  Reset mid-debounce:
//   - Aborts the debounce and forces S0.
//   - An input still high after reset needs a full 2+DB_CYCLES cycles and then yields a press.
// CONFIGURATION
//  RELEASE_EVT_EN defined:
//   - Adds output release_pulse[NUM_IN]: 1-cycle pulse on each accepted 1->0 transition.
//   - Release events also set pending/overrun, using the same rules as presses.
//  RELEASE_EVT_EN undefined:
//   - No release_pulse port; only presses set pending.
// TESTING (DB_CYCLES=8, NUM_IN=4)
//  1. raw_in[0] 0->1 at edge 0, held.
//     -> stable_out[0]=1 and press_pulse[0]=1 at edge 10 only; pending[0]=1 and irq=1 at edge 11.
//  2. raw_in[1] toggled every 3 cycles for 30 cycles, then held 1.
//     -> no pulses during bouncing; exactly one press_pulse[1], 10 cycles after the final edge.
//  3. raw_in[2] high for 7 cycles, then 0.
//     -> stable_out, press_pulse, pending all remain 0.
//  4. pending[0]=1; second press; clr_en=1 with clr_mask=4'b0001 in the same cycle as that press_pulse.
//     -> pending[0]=1 and overrun[0]=1 afterwards.
//  5. After case 4, clr_en=1 with clr_mask=4'b0001 and no press.
//     -> pending[0]=0, overrun[0]=0, irq=0 next cycle.
//  6. raw_in[3] high; rst=0 at debounce count 5, released 3 cycles later, raw still high.
//     -> all outputs 0 during reset; press_pulse[3] exactly 10 cycles after rst rises.

Source files
------------

// File: rtl/input_debounce_capture.sv
// ---------------------------------------------------------------------------
// input_debounce_capture
//
// Purpose:
//   Input-side front end between the board pins and the CPU input register
//   space. Each of NUM_IN raw buttons/switches is passed through a 2-flop
//   synchroniser and a per-bit 4-state debounce FSM. Accepted 0->1
//   transitions produce a single-cycle press pulse. Each press sets a sticky
//   pending flag, and sets a sticky overrun flag if pending was already set.
//   The CPU clears these flags with a one-cycle clear strobe plus a mask.
//
// Optional feature (macro RELEASE_EVT_EN):
//   When RELEASE_EVT_EN is defined, a release_pulse output is added. It
//   pulses for one cycle on each accepted 1->0 transition. Release events
//   also set pending/overrun under the same rules as presses.
//   When RELEASE_EVT_EN is not defined, the port does not exist and only
//   presses set pending.
//
// Ports:
//   clk           in   1       system clock
//   rst           in   1       asynchronous, active-low reset
//   raw_in        in   NUM_IN  asynchronous board inputs
//   clr_en        in   1       CPU clear strobe (one cycle)
//   clr_mask      in   NUM_IN  pending/overrun bits to clear when clr_en=1
//   stable_out    out  NUM_IN  debounced level (registered)
//   press_pulse   out  NUM_IN  one-cycle pulse per accepted 0->1 transition
//   release_pulse out  NUM_IN  one-cycle pulse per accepted 1->0 transition
//                              (present only with RELEASE_EVT_EN)
//   pending       out  NUM_IN  sticky event flag
//   overrun       out  NUM_IN  sticky: event arrived while pending was set
//   irq           out  1       registered OR of pending
// ---------------------------------------------------------------------------
module input_debounce_capture #(
    parameter int NUM_IN    = 4,
    parameter int CNT_W     = 16,
    parameter int DB_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] raw_in,
    input  logic              clr_en,
    input  logic [NUM_IN-1:0] clr_mask,
    output logic [NUM_IN-1:0] stable_out,
    output logic [NUM_IN-1:0] press_pulse,
`ifdef RELEASE_EVT_EN
    output logic [NUM_IN-1:0] release_pulse,
`endif
    output logic [NUM_IN-1:0] pending,
    output logic [NUM_IN-1:0] overrun,
    output logic              irq
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S0 = 2'd0,   // level 0, idle
        W1 = 2'd1,   // waiting to accept 1
        S1 = 2'd2,   // level 1, idle
        W0 = 2'd3    // waiting to accept 0
    } state_t;

    logic [NUM_IN-1:0] sync1_q;
    logic [NUM_IN-1:0] sync2_q;
    logic [NUM_IN-1:0] lvl;
    logic [NUM_IN-1:0] rise;
    logic [NUM_IN-1:0] fall;

    logic [NUM_IN-1:0] stable_q;
    logic [NUM_IN-1:0] press_q;
    logic [NUM_IN-1:0] release_q;
    logic [NUM_IN-1:0] pending_q;
    logic [NUM_IN-1:0] pending_d;
    logic [NUM_IN-1:0] overrun_q;
    logic [NUM_IN-1:0] overrun_d;
    logic              irq_q;
    logic [NUM_IN-1:0] set_evt;
    logic [NUM_IN-1:0] clr_vec;

    // Two-flop synchroniser; sync2_q is the only copy the FSMs look at.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < NUM_IN; i++) begin : g_bit
        state_t           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             lvl_q;
        logic             rise_q;
        logic             fall_q;

        // The counter holds the number of consecutive cycles the
        // synchronised input has disagreed with the accepted level. It is
        // cleared on every state change. Acceptance happens when the
        // counter already reads DB_CYCLES-1 and the input still disagrees,
        // so the counter never needs to go past DB_CYCLES-1.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= S0;
                cnt_q   <= '0;
                lvl_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                case (state_q)
                    S0: begin
                        if (sync2_q[i]) begin
                            state_q <= W1;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                    W1: begin
                        if (!sync2_q[i]) begin
                            state_q <= S0;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= S1;
                            cnt_q   <= '0;
                            lvl_q   <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    S1: begin
                        if (!sync2_q[i]) begin
                            state_q <= W0;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                    W0: begin
                        if (sync2_q[i]) begin
                            state_q <= S1;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= S0;
                            cnt_q   <= '0;
                            lvl_q   <= 1'b0;
                            fall_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= S0;
                        cnt_q   <= '0;
                        lvl_q   <= 1'b0;
                    end
                endcase
            end
        end

        assign lvl[i]  = lvl_q;
        assign rise[i] = rise_q;
        assign fall[i] = fall_q;
    end

    // Events are the registered pulses themselves, so pending/irq land one
    // cycle after the pulse. A set in the same cycle as a clear wins.
    always_comb begin
        set_evt = press_q;
`ifdef RELEASE_EVT_EN
        set_evt = press_q | release_q;
`endif
        clr_vec   = {NUM_IN{clr_en}} & clr_mask;
        pending_d = set_evt | (pending_q & ~clr_vec);
        overrun_d = (set_evt & pending_q) | (overrun_q & ~clr_vec);
    end

    // Output register stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            stable_q  <= lvl;
            press_q   <= rise;
            release_q <= fall;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            irq_q     <= |pending_d;
        end
    end

    assign stable_out  = stable_q;
    assign press_pulse = press_q;
`ifdef RELEASE_EVT_EN
    assign release_pulse = release_q;
`endif
    assign pending = pending_q;
    assign overrun = overrun_q;
    assign irq     = irq_q;

endmodule
